seq_alu: RTL

Parametrised, registered ALU with a valid/ready handshake on both sides. It is the successor to the combinational 8-bit datapath ALU. Width is generalised, all shifts take a variable amount, and SUB, SRA and an iterative multi-cycle MUL are added. It sits between the register-file read stage and writeback/branch logic, and can stall the core through `InReady`.

---
 rtl/seq_alu_pkg.sv | 27 ++
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu_mul.sv | 47 ++++
 rtl/seq_alu.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcode and FSM state encodings.
package seq_alu_pkg;

    localparam int ALU_FN_W = 4;

    // Codes 0-7 keep the legacy 3-bit datapath encoding.
    typedef enum logic [ALU_FN_W-1:0] {
        kADD = 4'd0,
        kOR  = 4'd1,
        kXOR = 4'd2,
        kAND = 4'd3,
        kLT  = 4'd4,
        kEQ  = 4'd5,
        kSLL = 4'd6,
        kSRL = 4'd7,
        kSUB = 4'd8,
        kSRA = 4'd9,
        kMUL = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operation/result handshake bundle between the operand source and seq_alu.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    import seq_alu_pkg::*;

    logic                InValid;
    logic                InReady;
    logic [WIDTH-1:0]    InputA;
    logic [WIDTH-1:0]    InputB;
    logic [ALU_FN_W-1:0] Function;
    logic                OutValid;
    logic                OutReady;
    logic [WIDTH-1:0]    Out;
    logic                takeBranch;
    logic                Zero;
    logic                Carry;
    logic                Illegal;

    modport master (
        output InValid, InputA, InputB, Function, OutReady,
        input  InReady, OutValid, Out, takeBranch, Zero, Carry, Illegal
    );

    modport slave (
        input  InValid, InputA, InputB, Function, OutReady,
        output InReady, OutValid, Out, takeBranch, Zero, Carry, Illegal
    );

endinterface

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Only instantiated when SEQ_ALU_MUL_EN is defined.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]        cnt_p1;
    logic [2*WIDTH-1:0]   acc_p1;
    logic [2*WIDTH-1:0]   mcand_p1;
    logic [WIDTH-1:0]     mplier_p1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_p1 <= '0;
        end else if (start) begin
            cnt_p1 <= CW'(WIDTH);
        end else if (cnt_p1 != '0) begin
            cnt_p1 <= cnt_p1 - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (start) begin
            acc_p1    <= '0;
            mcand_p1  <= {{WIDTH{1'b0}}, a};
            mplier_p1 <= b;
        end else if (cnt_p1 != '0) begin
            acc_p1    <= product;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
        end
    end

    // product is the accumulator after the current bit; on the last bit it is final.
    assign product = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
    assign done    = (cnt_p1 == CW'(1));

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake; iterative MUL present when
// SEQ_ALU_MUL_EN is defined, otherwise MUL decodes as an illegal opcode.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       Clk,
    input logic       Reset,
    seq_alu_if.slave  bus
);

    function automatic logic sh_in_range(input logic [WIDTH-1:0] amt);
        return (amt[WIDTH-1:SHW] == '0) && (amt[SHW-1:0] <= SHW'(WIDTH - 1));
    endfunction

    alu_state_t               state_p1;
    alu_state_t               state_nxt;
    alu_op_t                  op;
    logic                     in_ready;
    logic                     accept;
    logic                     is_mul;
    logic                     mul_done;
    logic                     load_alu;
    logic                     load_mul;
    logic                     vld_p1;
    logic [WIDTH:0]           sum_p0;
    logic [WIDTH:0]           diff_p0;
    logic signed [WIDTH-1:0]  a_s;
    logic [SHW-1:0]           sh;
    logic                     sh_ok;
    logic [WIDTH-1:0]         res_p0;
    logic                     carry_p0;
    logic                     illegal_p0;
    logic [WIDTH-1:0]         nxt_res;
    logic                     nxt_carry;
    logic                     nxt_illegal;
    logic [WIDTH-1:0]         out_p1;
    logic                     zero_p1;
    logic                     carry_p1;
    logic                     illegal_p1;
    logic                     branch_p1;

    assign op      = alu_op_t'(bus.Function);
    assign sum_p0  = {1'b0, bus.InputA} + {1'b0, bus.InputB};
    assign diff_p0 = {1'b0, bus.InputA} - {1'b0, bus.InputB};
    assign a_s     = $signed(bus.InputA);
    assign sh      = bus.InputB[SHW-1:0];
    assign sh_ok   = sh_in_range(bus.InputB);

    // Stage p0: single-cycle datapath on the operands offered this cycle.
    always_comb begin
        res_p0     = '0;
        carry_p0   = 1'b0;
        illegal_p0 = 1'b0;
        case (op)
            kADD: begin
                res_p0   = sum_p0[WIDTH-1:0];
                carry_p0 = sum_p0[WIDTH];
            end
            kOR:  res_p0 = bus.InputA | bus.InputB;
            kXOR: res_p0 = bus.InputA ^ bus.InputB;
            kAND: res_p0 = bus.InputA & bus.InputB;
            kLT:  res_p0 = {{(WIDTH-1){1'b0}}, (bus.InputA < bus.InputB)};
            kEQ:  res_p0 = {{(WIDTH-1){1'b0}}, (bus.InputA == bus.InputB)};
            kSLL: res_p0 = sh_ok ? (bus.InputA << sh) : '0;
            kSRL: res_p0 = sh_ok ? (bus.InputA >> sh) : '0;
            kSUB: begin
                res_p0   = diff_p0[WIDTH-1:0];
                carry_p0 = diff_p0[WIDTH];
            end
            kSRA: res_p0 = sh_ok ? $unsigned(a_s >>> sh) : {WIDTH{bus.InputA[WIDTH-1]}};
`ifdef SEQ_ALU_MUL_EN
            kMUL: res_p0 = '0;
`endif
            default: illegal_p0 = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_product;

    assign is_mul = (op == kMUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (accept && is_mul),
        .a       (bus.InputA),
        .b       (bus.InputB),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_p1 <= IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            IDLE: if (accept) state_nxt = is_mul ? BUSY : DONE;
            BUSY: if (mul_done) state_nxt = DONE;
            DONE: if (bus.OutReady) state_nxt = accept ? (is_mul ? BUSY : DONE) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = !Reset && (state_p1 == IDLE || (state_p1 == DONE && bus.OutReady));
        accept   = bus.InValid && in_ready;
        load_alu = accept && !is_mul;
        load_mul = (state_p1 == BUSY) && mul_done;
        vld_p1   = (state_p1 == DONE);
    end

    always_comb begin
        nxt_res     = res_p0;
        nxt_carry   = carry_p0;
        nxt_illegal = illegal_p0;
`ifdef SEQ_ALU_MUL_EN
        if (load_mul) begin
            nxt_res     = mul_product[WIDTH-1:0];
            nxt_carry   = |mul_product[2*WIDTH-1:WIDTH];
            nxt_illegal = 1'b0;
        end
`endif
    end

    // Stage p1: result registers, held until the next load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_p1     <= '0;
            zero_p1    <= 1'b1;
            carry_p1   <= 1'b0;
            illegal_p1 <= 1'b0;
            branch_p1  <= 1'b0;
        end else if (load_alu || load_mul) begin
            out_p1     <= nxt_res;
            zero_p1    <= (nxt_res == '0);
            carry_p1   <= nxt_carry;
            illegal_p1 <= nxt_illegal;
            branch_p1  <= (nxt_res != '0);
        end
    end

    assign bus.InReady    = in_ready;
    assign bus.OutValid   = vld_p1;
    assign bus.Out        = out_p1;
    assign bus.Zero       = zero_p1;
    assign bus.Carry      = carry_p1;
    assign bus.Illegal    = illegal_p1;
    assign bus.takeBranch = branch_p1;

endmodule
